sfq_pulse_deser: RTL

SFQ_PULSE_DESER -- requirements
Module: sfq_pulse_deser

---
 rtl/sfq_deser_pkg.sv | 18 +
 rtl/sfq_toggle_det.sv | 30 +++
 rtl/sfq_pulse_deser.sv | 123 ++++++++++++
 3 files changed

// File: rtl/sfq_deser_pkg.sv
// Shared types and constants for the SFQ pulse deserialiser.
// Used by sfq_pulse_deser (optional parity output: SFQ_PULSE_DESER_PARITY_EN).
package sfq_deser_pkg;

    typedef enum logic {
        ARM = 1'b0,
        RUN = 1'b1
    } sfq_state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 16;

    // Bit-index register width; never below one bit.
    function automatic int idx_w(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/sfq_toggle_det.sv
// Toggle-to-pulse converter for the SFQ stream: double register, edge compare,
// and reference capture while the parent FSM is arming.
module sfq_toggle_det (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sfq,
    input  logic i_arm,
    output logic o_pulse
);

    logic r_in;
    logic r_prev;

    // Sample the stream; while arming both stages load the same reference level.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_in   <= 1'b0;
            r_prev <= 1'b0;
        end else if (i_arm) begin
            r_in   <= i_sfq;
            r_prev <= i_sfq;
        end else begin
            r_in   <= i_sfq;
            r_prev <= r_in;
        end
    end

    assign o_pulse = (r_in ^ r_prev) & ~i_arm;

endmodule

// File: rtl/sfq_pulse_deser.sv
// SFQ pulse deserialiser: one bit per clock window, MSB-first, with double-pulse flag.
// Optional registered word parity output enabled by SFQ_PULSE_DESER_PARITY_EN.
module sfq_pulse_deser
    import sfq_deser_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sfq_in,
    input  logic             win,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             dbl_err,
    output logic [CNT_W-1:0] pulse_cnt
`ifdef SFQ_PULSE_DESER_PARITY_EN
    ,
    output logic             parity
`endif
);

    localparam int IW = idx_w(WIDTH);
    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

    sfq_state_t       r_state;
    logic [IW-1:0]    r_idx;
    logic             r_hit;
    logic             r_werr;
    logic [WIDTH-2:0] r_shift;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_dbl;
    logic [CNT_W-1:0] r_cnt;
`ifdef SFQ_PULSE_DESER_PARITY_EN
    logic             r_parity;
`endif

    logic             w_pulse;
    logic             w_bit;
    logic             w_werr;
    logic [WIDTH-1:0] w_word;

    sfq_toggle_det u_det (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_sfq   (sfq_in),
        .i_arm   (r_state == ARM),
        .o_pulse (w_pulse)
    );

    // A pulse in the win cycle still belongs to the window being closed.
    assign w_bit  = r_hit | w_pulse;
    assign w_werr = r_werr | (r_hit & w_pulse);
    assign w_word = {r_shift, w_bit};

    // Arm/run FSM with window accumulation, word assembly and pulse counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ARM;
            r_idx    <= '0;
            r_hit    <= 1'b0;
            r_werr   <= 1'b0;
            r_shift  <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_dbl    <= 1'b0;
            r_cnt    <= '0;
`ifdef SFQ_PULSE_DESER_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ARM: begin
                    r_state <= RUN;
                end
                RUN: begin
                    r_cnt <= r_cnt + CNT_W'(w_pulse);
                    if (!en) begin
                        r_idx  <= '0;
                        r_hit  <= 1'b0;
                        r_werr <= 1'b0;
                    end else if (win) begin
                        r_shift <= w_word[WIDTH-2:0];
                        r_hit   <= 1'b0;
                        if (r_idx == LAST) begin
                            r_data   <= w_word;
                            r_valid  <= 1'b1;
                            r_dbl    <= w_werr;
                            r_idx    <= '0;
                            r_werr   <= 1'b0;
`ifdef SFQ_PULSE_DESER_PARITY_EN
                            r_parity <= ^w_word;
`endif
                        end else begin
                            r_idx  <= r_idx + IW'(1);
                            r_werr <= w_werr;
                        end
                    end else if (w_pulse) begin
                        r_hit  <= 1'b1;
                        r_werr <= r_werr | r_hit;
                    end else begin
                        r_hit <= r_hit;
                    end
                end
                default: begin
                    r_state <= ARM;
                end
            endcase
        end
    end

    assign data      = r_data;
    assign valid     = r_valid;
    assign dbl_err   = r_dbl;
    assign pulse_cnt = r_cnt;
`ifdef SFQ_PULSE_DESER_PARITY_EN
    assign parity    = r_parity;
`endif

endmodule
